// File: rtl/riscv_defines.sv
// rtl/riscv_defines.sv - shared ALU operator encodings and divider FSM types
package riscv_defines;

  localparam int ALU_OP_WIDTH = 7;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_DIVU = 7'b0110000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_DIV  = 7'b0110001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_REMU = 7'b0110010;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_REM  = 7'b0110011;

  localparam int DIV_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    FIX,
    RESP
  } div_state_e;

endpackage

// File: rtl/riscv_rr_arbiter.sv
// rtl/riscv_rr_arbiter.sv - round-robin arbiter with one-hot grant and owner index
module riscv_rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] owner
);

  logic [IW-1:0] ptr;

  // Scan from farthest to nearest so the requester closest to ptr wins last.
  always_comb begin
    int j;
    j     = 0;
    gnt   = '0;
    owner = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        owner  = IW'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (en && |req) begin
      ptr <= (int'(owner) == N - 1) ? '0 : owner + 1'b1;
    end
  end

endmodule

// File: rtl/riscv_shared_div_unit.sv
// rtl/riscv_shared_div_unit.sv - shared multi-cycle DIV/DIVU/REM/REMU responder for several cores
module riscv_shared_div_unit
  import riscv_defines::*;
#(
  parameter int NUM_CORES = 2,
  parameter int ALU_OP_W  = ALU_OP_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CORES-1:0]          req_i,
  input  logic [NUM_CORES*ALU_OP_W-1:0] operator_i,
  input  logic [NUM_CORES*32-1:0]       operand_a_i,
  input  logic [NUM_CORES*32-1:0]       operand_b_i,
  output logic [NUM_CORES-1:0]          gnt_o,
  output logic [NUM_CORES-1:0]          rvalid_o,
  output logic [31:0]                   result_o,
  input  logic [NUM_CORES-1:0]          ex_ready_i,
  output logic                          busy_o
);

  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  div_state_e           state;
  logic [IW-1:0]        owner_q;
  logic [ALU_OP_W-1:0]  op_q;
  logic [31:0]          dvd_q, dsr_q, rem_q, spec_q;
  logic                 neg_q_q, neg_r_q, special_q;
  logic [DIV_CNT_W-1:0] cnt_q;

  logic [NUM_CORES-1:0] arb_gnt;
  logic [IW-1:0]        arb_owner;

  riscv_rr_arbiter #(.N(NUM_CORES)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_i),
    .en    (state == IDLE),
    .gnt   (arb_gnt),
    .owner (arb_owner)
  );

  logic [ALU_OP_W-1:0] sel_op;
  logic [31:0]         sel_a, sel_b, abs_a, abs_b, spec_val;
  logic                is_signed, is_div_op, special;

  always_comb begin
    sel_op    = operator_i[int'(arb_owner)*ALU_OP_W +: ALU_OP_W];
    sel_a     = operand_a_i[int'(arb_owner)*32 +: 32];
    sel_b     = operand_b_i[int'(arb_owner)*32 +: 32];
    is_signed = (sel_op == ALU_DIV) || (sel_op == ALU_REM);
    is_div_op = is_signed || (sel_op == ALU_DIVU) || (sel_op == ALU_REMU);
    abs_a     = (is_signed && sel_a[31]) ? -sel_a : sel_a;
    abs_b     = (is_signed && sel_b[31]) ? -sel_b : sel_b;
    special   = 1'b1;
    spec_val  = '0;
    if (!is_div_op) begin
      spec_val = '0;
    end else if (sel_b == '0) begin
      spec_val = ((sel_op == ALU_DIV) || (sel_op == ALU_DIVU)) ? 32'hFFFF_FFFF : sel_a;
    end else if (is_signed && sel_a == 32'h8000_0000 && sel_b == 32'hFFFF_FFFF) begin
      spec_val = (sel_op == ALU_DIV) ? 32'h8000_0000 : 32'h0;
    end else begin
      special = 1'b0;
    end
  end

  // Restoring step: the shifted partial remainder needs 33 bits before the compare.
  logic [32:0] rem_shift;
  logic        q_bit;
  logic        is_rem_q;

  assign rem_shift = {rem_q, dvd_q[31]};
  assign q_bit     = rem_shift >= {1'b0, dsr_q};
  assign is_rem_q  = (op_q == ALU_REM) || (op_q == ALU_REMU);

  assign gnt_o  = (state == IDLE && rst_n) ? arb_gnt : '0;
  assign busy_o = (state != IDLE);

  always_comb begin
    rvalid_o = '0;
    if (state == RESP) rvalid_o[owner_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner_q   <= '0;
      op_q      <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      spec_q    <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      special_q <= 1'b0;
      cnt_q     <= '0;
      result_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_i) begin
            owner_q   <= arb_owner;
            op_q      <= sel_op;
            dvd_q     <= abs_a;
            dsr_q     <= abs_b;
            rem_q     <= '0;
            cnt_q     <= DIV_CNT_W'(31);
            neg_q_q   <= is_signed && (sel_a[31] ^ sel_b[31]);
            neg_r_q   <= is_signed && sel_a[31];
            special_q <= special;
            spec_q    <= spec_val;
            state     <= special ? FIX : DIV;
          end
        end
        DIV: begin
          rem_q <= q_bit ? 32'(rem_shift - {1'b0, dsr_q}) : rem_shift[31:0];
          dvd_q <= {dvd_q[30:0], q_bit};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) state <= FIX;
        end
        FIX: begin
          if (special_q)     result_o <= spec_q;
          else if (is_rem_q) result_o <= neg_r_q ? -rem_q : rem_q;
          else               result_o <= neg_q_q ? -dvd_q : dvd_q;
          state <= RESP;
        end
        RESP: begin
          if (ex_ready_i[owner_q]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_shared_div_unit.sv
// tb/tb_riscv_shared_div_unit.sv - self-checking bench for riscv_shared_div_unit
module tb_riscv_shared_div_unit;
  import riscv_defines::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_i = '0;
  logic [13:0] operator_i = '0;
  logic [63:0] operand_a_i = '0;
  logic [63:0] operand_b_i = '0;
  logic [1:0]  gnt_o, rvalid_o, ex_ready_i = 2'b11;
  logic [31:0] result_o;
  logic        busy_o;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  riscv_shared_div_unit #(.NUM_CORES(2), .ALU_OP_W(ALU_OP_WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .operator_i  (operator_i),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .gnt_o       (gnt_o),
    .rvalid_o    (rvalid_o),
    .result_o    (result_o),
    .ex_ready_i  (ex_ready_i),
    .busy_o      (busy_o)
  );

  typedef struct {
    int          core;
    logic [6:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          hold;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: RISC-V M-extension semantics from plain integer arithmetic.
  function automatic logic [31:0] model(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
    int  sa, sb;
    bit  ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      ALU_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      ALU_REMU: return (b == 0) ? a : a % b;
      ALU_DIV:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      ALU_REM:  return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default:  return 32'h0;
    endcase
  endfunction

  function automatic int model_lat(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
    bit sgn, divop;
    sgn   = (op == ALU_DIV) || (op == ALU_REM);
    divop = sgn || (op == ALU_DIVU) || (op == ALU_REMU);
    if (!divop || b == 0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 2;
    return 34;
  endfunction

  task automatic drive_core(input int core, input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
    operator_i[core*7 +: 7]   = op;
    operand_a_i[core*32 +: 32] = a;
    operand_b_i[core*32 +: 32] = b;
  endtask

  task automatic do_op(input vec_t v);
    logic [1:0]  oh;
    logic [31:0] r;
    int          lat;
    bit          gbad, stable;
    oh = 2'b01 << v.core;
    @(posedge clk); #1;
    drive_core(v.core, v.op, v.a, v.b);
    ex_ready_i = (v.hold > 0) ? ~oh : 2'b11;
    req_i = oh;
    @(negedge clk);
    chk("gnt", 32'(gnt_o), 32'(oh));
    @(posedge clk); #1;
    req_i = '0;
    lat  = 0;
    gbad = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (gnt_o != 0) gbad = 1;
      if (rvalid_o != 0) begin
        lat = c;
        break;
      end
    end
    chk("latency", 32'(lat), 32'(v.lat));
    chk("no_gnt_while_busy", 32'(gbad), 32'd0);
    if (lat == 0) return;
    chk("rvalid", 32'(rvalid_o), 32'(oh));
    chk("result", result_o, v.exp);
    r = result_o;
    stable = 1;
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      if (rvalid_o !== oh || result_o !== r) stable = 0;
    end
    if (v.hold > 0) chk("hold_stable", 32'(stable), 32'd1);
    ex_ready_i[v.core] = 1'b1;
    @(posedge clk); #1;
    chk("idle_after", {29'd0, busy_o, rvalid_o}, 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_outputs", {27'd0, gnt_o, rvalid_o, busy_o}, 32'd0);
    chk("reset_result", result_o, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t       v;
    logic [1:0] g;
    logic [6:0] ops[5];
    logic [31:0] ra[2], rb[2];
    logic [6:0] rop[2];
    bit         gbad;
    int         w;

    tbl[0]  = '{0, ALU_DIVU, 32'd100,        32'd7,          0, 32'd14,         34};
    tbl[1]  = '{0, ALU_REMU, 32'd100,        32'd7,          0, 32'd2,          34};
    tbl[2]  = '{1, ALU_DIV,  32'hFFFF_FFF9,  32'd2,          0, 32'hFFFF_FFFD,  34};
    tbl[3]  = '{1, ALU_REM,  32'hFFFF_FFF9,  32'd2,          0, 32'hFFFF_FFFF,  34};
    tbl[4]  = '{0, ALU_DIVU, 32'h1234,       32'd0,          0, 32'hFFFF_FFFF,  2};
    tbl[5]  = '{1, ALU_REM,  32'h1234,       32'd0,          0, 32'h1234,       2};
    tbl[6]  = '{0, ALU_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  0, 32'h8000_0000,  2};
    tbl[7]  = '{1, ALU_REM,  32'h8000_0000,  32'hFFFF_FFFF,  0, 32'h0,          2};
    tbl[8]  = '{0, ALU_DIVU, 32'hFFFF_FFFF,  32'd1,          0, 32'hFFFF_FFFF,  34};
    tbl[9]  = '{1, ALU_DIVU, 32'd100,        32'd7,          5, 32'd14,         34};
    tbl[10] = '{0, 7'd0,     32'd55,         32'd5,          0, 32'h0,          2};

    ops[0] = ALU_DIV; ops[1] = ALU_DIVU; ops[2] = ALU_REM; ops[3] = ALU_REMU; ops[4] = 7'd0;

    #1;
    chk("reset_state", {27'd0, gnt_o, rvalid_o, busy_o}, 32'd0);
    chk("reset_result", result_o, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) do_op(tbl[i]);

    for (int i = 0; i < 24; i++) begin
      v.core = int'($urandom_range(0, 1));
      v.op   = ops[$urandom_range(0, 4)];
      v.a    = $urandom;
      case ($urandom_range(0, 5))
        0:       v.b = 32'd0;
        1, 2:    v.b = 32'($urandom_range(1, 20));
        3:       v.b = -32'($urandom_range(1, 20));
        default: v.b = $urandom;
      endcase
      v.hold = int'($urandom_range(0, 2));
      v.exp  = model(v.op, v.a, v.b);
      v.lat  = model_lat(v.op, v.a, v.b);
      do_op(v);
    end

    // Both cores requesting continuously: strict alternation from pointer 0.
    pulse_reset();
    rop[0] = ALU_DIVU; ra[0] = 32'd1000;       rb[0] = 32'd3;
    rop[1] = ALU_DIV;  ra[1] = 32'hFFFF_FF9C;  rb[1] = 32'd7;
    drive_core(0, rop[0], ra[0], rb[0]);
    drive_core(1, rop[1], ra[1], rb[1]);
    ex_ready_i = 2'b11;
    req_i = 2'b11;
    for (int k = 0; k < 4; k++) begin
      g = '0;
      for (int c = 0; c < 60 && g == 0; c++) begin
        @(negedge clk);
        g = gnt_o;
      end
      chk("rr_gnt", 32'(g), 32'(2'b01 << (k % 2)));
      gbad = 0;
      w = 0;
      for (int c = 1; c <= 60; c++) begin
        @(negedge clk);
        if (busy_o && gnt_o != 0) gbad = 1;
        if (rvalid_o != 0) begin
          w = c;
          break;
        end
      end
      chk("rr_rvalid", 32'(rvalid_o), 32'(g));
      chk("rr_result", result_o, model(rop[k % 2], ra[k % 2], rb[k % 2]));
      chk("rr_no_gnt_busy", 32'(gbad), 32'd0);
    end
    req_i = '0;
    for (int c = 0; c < 60 && busy_o; c++) @(negedge clk);

    // Reset in the middle of a divide, with a request still pending.
    @(posedge clk); #1;
    drive_core(1, ALU_DIVU, 32'd5000, 32'd9);
    req_i = 2'b10;
    @(negedge clk);
    chk("mid_gnt", 32'(gnt_o), 32'(2'b10));
    for (int c = 1; c <= 15; c++) @(negedge clk);
    chk("mid_busy", 32'(busy_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs", {27'd0, gnt_o, rvalid_o, busy_o}, 32'd0);
    chk("mid_reset_result", result_o, 32'd0);
    req_i = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    v = '{0, ALU_DIVU, 32'd1000, 32'd10, 0, 32'd100, 34};
    do_op(v);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
